rsa_power_policy: RTL and testbench
===================================

// Module: rsa_power_policy
// PURPOSE
//  Idle-driven power policy controller directly upstream of rsa_power_control.
//  Watches RSA core activity and host job requests. Drives req_disable after a
//  programmable idle period and req_enable when work arrives.
//  Completes each request only on mode_change_ack.
//  Gates host job grants until the core is powered and settled after wake-up.
// PARAMETERS
//  IDLE_CYCLES  1024  consecutive idle cycles before power-down request (>=1)
//  WAKE_SETTLE  8     cycles held in SETTLE after enable ack before grants (>=1)
//  ACK_TIMEOUT  4096  cycles waiting for mode_change_ack before error flag (>=1)
// PORTS
//  clk              in   1  clock
//  rst              in   1  reset, synchronous, active-high
//  sleep_en         in   1  policy enable; 0 = never power down
//  core_busy        in   1  RSA core has work in flight
//  job_req          in   1  host requests a new job (level, held until job_gnt)
//  force_wake       in   1  wake request without a job (debug/SW)
//  mode_change_ack  in   1  pulse from rsa_power_control
//  clear_err        in   1  clears ack_timeout_err
//  job_gnt          out  1  job accepted this cycle (= job_req while in ON)
//  req_disable      out  1  to rsa_power_control; level, held until ack
//  req_enable       out  1  to rsa_power_control; level, held until ack
//  powered          out  1  1 in ON/REQ_OFF/SETTLE, 0 in OFF/REQ_ON
//  ack_timeout_err  out  1  sticky: an ack wait exceeded ACK_TIMEOUT
// BEHAVIOUR
//  - Reset: state ON, idle_cnt=0, wait_cnt=0, settle_cnt=0.
//  - Outputs after reset: req_disable=0, req_enable=0, powered=1, ack_timeout_err=0.
//  - Reset state ON matches rsa_power_control powered state after rst.
//  - req_disable, req_enable and powered are decoded from the state register only.
//    They are glitch-free and change one cycle after the state decision.
//  - job_gnt = (state==ON) & job_req, combinational.
//  - idle condition: sleep_en & ~core_busy & ~job_req.
//  - States and transitions:
//    ON: idle_cnt += 1 on each idle cycle, else cleared to 0.
//      If idle and idle_cnt==IDLE_CYCLES-1: next REQ_OFF, idle_cnt cleared.
//      => req_disable high exactly IDLE_CYCLES cycles after the first idle cycle.
//    REQ_OFF: req_disable=1. On mode_change_ack: next OFF.
//      Not abortable: job_req, sleep_en=0 and force_wake are ignored until OFF.
//      No grants are issued in this state.
//    OFF: if job_req | force_wake: next REQ_ON, same cycle the condition is seen.
//    REQ_ON: req_enable=1. On mode_change_ack: next SETTLE, settle_cnt cleared.
//    SETTLE: settle_cnt += 1. At WAKE_SETTLE-1: next ON, idle_cnt cleared.
//  - mode_change_ack outside REQ_OFF/REQ_ON is ignored.
//  - wait_cnt clears on entry to REQ_OFF/REQ_ON and increments each cycle there.
//    It saturates at ACK_TIMEOUT.
//    When it reaches ACK_TIMEOUT without an ack, ack_timeout_err is set.
//    The FSM keeps waiting and keeps the request asserted.
//    A late ack still completes the transition normally.
//  - ack_timeout_err clears on clear_err or rst.
//    If set and clear are in the same cycle, set wins.
//  - Simultaneous events:
//    - In ON, job_req and an idle-threshold hit cannot coincide, since job_req breaks idle.
//    - In OFF, job_req and force_wake together give a single wake.
//  - Counter widths: $clog2(PARAM+1) each, no wrap. Idle and settle counters are bounded by their compares.
//  - rst mid-request: immediate return to ON with all outputs at reset values.
//    The same rst must also reset rsa_power_control.
// TESTING
//  1. IDLE_CYCLES=16, sleep_en=1, idle from cycle 0:
//     req_disable=1 from cycle 16. Ack at cycle 20 -> req_disable=0 and powered=0 at cycle 21.
//  2. core_busy pulse at idle cycle 10 -> idle count restarts.
//     req_disable rises 16 cycles after core_busy falls.
//  3. In OFF, job_req=1 -> req_enable=1 next cycle. Ack 5 cycles later -> SETTLE for 8 cycles (WAKE_SETTLE=8).
//     Then ON with job_gnt=1 while job_req is held.
//  4. job_req raised in REQ_OFF -> no grant. Ack -> OFF for 1 cycle -> REQ_ON (req_enable=1).
//  5. ACK_TIMEOUT=32, ack withheld -> ack_timeout_err=1 after 32 cycles in REQ_OFF, req_disable stays 1.
//     Late ack -> OFF. clear_err -> err=0.
//  6. sleep_en=0 for 5000 idle cycles -> req_disable never asserted.
//     rst asserted in REQ_ON -> next cycle ON, powered=1, req_enable=0.

Source files
------------

// File: rtl/rsa_power_policy.sv
// Idle-driven power policy ahead of rsa_power_control.
// Requests power-down after idle, wake on work, gates grants until settled.
module rsa_power_policy #(
  parameter int IDLE_CYCLES = 1024,
  parameter int WAKE_SETTLE = 8,
  parameter int ACK_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic sleep_en,
  input  logic core_busy,
  input  logic job_req,
  input  logic force_wake,
  input  logic mode_change_ack,
  input  logic clear_err,
  output logic job_gnt,
  output logic req_disable,
  output logic req_enable,
  output logic powered,
  output logic ack_timeout_err
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int SW = $clog2(WAKE_SETTLE + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_ON,
    S_REQ_OFF,
    S_OFF,
    S_REQ_ON,
    S_SETTLE
  } state_t;

  state_t state, state_nx;

  logic [IW-1:0] idle_cnt, idle_nx;
  logic [SW-1:0] settle_cnt, settle_nx;
  logic [AW-1:0] wait_cnt, wait_nx;

  logic idle;
  logic in_req;
  logic err_set;

  assign idle    = sleep_en & ~core_busy & ~job_req;
  assign in_req  = (state == S_REQ_OFF) | (state == S_REQ_ON);
  assign job_gnt = (state == S_ON) & job_req;

  // err fires on the cycle wait_cnt steps onto ACK_TIMEOUT
  assign err_set = in_req & ~mode_change_ack &
                   (wait_cnt == AW'(ACK_TIMEOUT - 1));

  always_comb begin
    state_nx  = state;
    idle_nx   = idle_cnt;
    settle_nx = settle_cnt;
    wait_nx   = wait_cnt;
    unique case (state)
      S_ON: begin
        if (!idle) begin
          idle_nx = '0;
        end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
          state_nx = S_REQ_OFF;
          idle_nx  = '0;
          wait_nx  = '0;
        end else begin
          idle_nx = idle_cnt + 1'b1;
        end
      end
      S_REQ_OFF, S_REQ_ON: begin
        if (mode_change_ack) begin
          if (state == S_REQ_OFF) begin
            state_nx = S_OFF;
          end else begin
            state_nx  = S_SETTLE;
            settle_nx = '0;
          end
        end else if (wait_cnt != AW'(ACK_TIMEOUT)) begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      S_OFF: begin
        if (job_req | force_wake) begin
          state_nx = S_REQ_ON;
          wait_nx  = '0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SW'(WAKE_SETTLE - 1)) begin
          state_nx  = S_ON;
          idle_nx   = '0;
          settle_nx = '0;
        end else begin
          settle_nx = settle_cnt + 1'b1;
        end
      end
      default: state_nx = S_ON;
    endcase
  end

  // Outputs are flops fed by the next state: glitch-free, one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_ON;
      idle_cnt        <= '0;
      settle_cnt      <= '0;
      wait_cnt        <= '0;
      req_disable     <= 1'b0;
      req_enable      <= 1'b0;
      powered         <= 1'b1;
      ack_timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      idle_cnt    <= idle_nx;
      settle_cnt  <= settle_nx;
      wait_cnt    <= wait_nx;
      req_disable <= (state_nx == S_REQ_OFF);
      req_enable  <= (state_nx == S_REQ_ON);
      powered     <= (state_nx == S_ON) |
                     (state_nx == S_REQ_OFF) |
                     (state_nx == S_SETTLE);
      if (err_set) begin
        ack_timeout_err <= 1'b1;
      end else if (clear_err) begin
        ack_timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsa_power_policy.sv
// Scoreboard bench for rsa_power_policy.
// Expected vectors {gnt,dis,en,pwr,err} are queued then popped on sample.
module tb_rsa_power_policy;

  localparam int IDLE = 16;
  localparam int SETL = 8;
  localparam int TMO  = 32;

  logic clk = 1'b0;
  logic rst;
  logic sleep_en;
  logic core_busy;
  logic job_req;
  logic force_wake;
  logic mode_change_ack;
  logic clear_err;
  logic job_gnt;
  logic req_disable;
  logic req_enable;
  logic powered;
  logic ack_timeout_err;

  rsa_power_policy #(
    .IDLE_CYCLES(IDLE),
    .WAKE_SETTLE(SETL),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sleep_en(sleep_en),
    .core_busy(core_busy),
    .job_req(job_req),
    .force_wake(force_wake),
    .mode_change_ack(mode_change_ack),
    .clear_err(clear_err),
    .job_gnt(job_gnt),
    .req_disable(req_disable),
    .req_enable(req_enable),
    .powered(powered),
    .ack_timeout_err(ack_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  function automatic logic [15:0] outs();
    return {11'b0, job_gnt, req_disable, req_enable,
            powered, ack_timeout_err};
  endfunction

  function automatic logic [15:0] vec(bit g, bit d, bit e,
                                      bit p, bit r);
    return {11'b0, g, d, e, p, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    sleep_en        = 1'b0;
    core_busy       = 1'b0;
    job_req         = 1'b0;
    force_wake      = 1'b0;
    mode_change_ack = 1'b0;
    clear_err       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [15:0] o;
    do_reset();
    sb.push_back('{"reset", vec(0, 0, 0, 1, 0)});
    #1;
    e = sb.pop_front();
    o = outs();
    total++;
    if (o !== e.v)
      $display("FAIL %s: got %h want %h", e.tag, o, e.v);
    else
      passed++;
  endtask

  task automatic test_idle_power_down();
    exp_t e;
    logic [15:0] o;
    do_reset();
    sleep_en = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      mode_change_ack = (c == 20);
      sb.push_back('{$sformatf("idle c%0d", c),
                     vec(0, c >= 16 && c <= 20, 0, c <= 20, 0)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    mode_change_ack = 1'b0;
  endtask

  // Starts in OFF, left there by test_idle_power_down
  task automatic test_wake();
    exp_t e;
    logic [15:0] o;
    job_req = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      mode_change_ack = (c == 6);
      sb.push_back('{$sformatf("wake c%0d", c),
                     vec(c >= 15, 0, c >= 1 && c <= 6, c >= 7, 0)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    mode_change_ack = 1'b0;
    job_req         = 1'b0;
  endtask

  task automatic test_busy_restart();
    exp_t e;
    logic [15:0] o;
    do_reset();
    sleep_en = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      core_busy       = (c == 10);
      mode_change_ack = (c == 5);
      sb.push_back('{$sformatf("busy c%0d", c),
                     vec(0, c >= 27, 0, 1, 0)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    core_busy       = 1'b0;
    mode_change_ack = 1'b0;
  endtask

  task automatic test_job_in_req_off();
    exp_t e;
    logic [15:0] o;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      sleep_en        = (c < 18);
      force_wake      = (c == 19);
      job_req         = (c >= 17);
      mode_change_ack = (c == 20) || (c == 23);
      sb.push_back('{$sformatf("reqoff_job c%0d", c),
                     vec(0, c >= 16 && c <= 20,
                         c == 22 || c == 23,
                         !(c >= 21 && c <= 23), 0)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    job_req         = 1'b0;
    force_wake      = 1'b0;
    mode_change_ack = 1'b0;
  endtask

  task automatic test_ack_timeout();
    exp_t e;
    logic [15:0] o;
    do_reset();
    sleep_en = 1'b1;
    for (int c = 0; c <= 56; c++) begin
      mode_change_ack = (c == 52);
      clear_err       = (c == 47) || (c == 54);
      sb.push_back('{$sformatf("timeout c%0d", c),
                     vec(0, c >= 16 && c <= 52, 0, c <= 52,
                         c >= 48 && c <= 54)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    mode_change_ack = 1'b0;
    clear_err       = 1'b0;
  endtask

  task automatic test_sleep_disabled();
    exp_t e;
    logic [15:0] o;
    int hits;
    do_reset();
    hits = 0;
    sb.push_back('{"sleep_off_dis_cycles", 16'd0});
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (req_disable !== 1'b0) hits++;
    end
    e = sb.pop_front();
    o = hits[15:0];
    total++;
    if (o !== e.v)
      $display("FAIL %s: got %0d want %0d", e.tag, o, e.v);
    else
      passed++;
  endtask

  task automatic test_rst_mid_request();
    exp_t e;
    logic [15:0] o;
    do_reset();
    sleep_en = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      mode_change_ack = (c == 20);
      job_req         = (c == 21);
      rst             = (c == 23);
      sb.push_back('{$sformatf("rst_mid c%0d", c),
                     vec(0, c >= 16 && c <= 20,
                         c == 22 || c == 23,
                         !(c >= 21 && c <= 23), 0)});
      #1;
      e = sb.pop_front();
      o = outs();
      total++;
      if (o !== e.v)
        $display("FAIL %s: got %h want %h", e.tag, o, e.v);
      else
        passed++;
      tick();
    end
    rst             = 1'b0;
    job_req         = 1'b0;
    mode_change_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_power_down();
    test_wake();
    test_busy_restart();
    test_job_in_req_off();
    test_ack_timeout();
    test_sleep_disabled();
    test_rst_mid_request();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
